// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator core and its display controller.
package calc_pkg;

    typedef enum logic [1:0] {
        ERRO    = 2'd0,
        PRONTA  = 2'd1,
        OCUPADA = 2'd2
    } statetype;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } ctrlState_t;

    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic [3:0]  ERR_CODE   = 4'hE;
    localparam logic [31:0] MAX_VALUE  = 32'd99999999;

endpackage

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter: one add-3/shift step per clock, BIN_W steps per conversion.
module bcd_double_dabble #(
    parameter int BIN_W = 32,
    parameter int BCD_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             finish
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic [BCD_W-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= CNT_W'(BIN_W);
        end else if (r_cnt != '0) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // High during the final shift so the controller can step to COMMIT on the same edge.
    assign finish = (r_cnt == CNT_W'(1));
    assign bcd    = r_bcd;

endmodule

// File: rtl/calc_display_ctrl.sv
// Converts the calculator result to BCD and scans it onto the shared pos/dig bus.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero one.
module calc_display_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1000,
    parameter int BIN_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BIN_W-1:0] value,
    input  logic             load,
    input  logic [1:0]       status,
    output logic             busy,
    output logic             done,
    output logic [3:0]       pos,
    output logic [3:0]       dig
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int SCAN_W = $clog2(SCAN_DIV);

    ctrlState_t        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_pendValid;
    logic [BIN_W-1:0]  r_pendVal;
    logic [BCD_W-1:0]  r_disp;
    logic [SCAN_W-1:0] r_scanCnt;
    logic [3:0]        r_pos;
    logic [3:0]        r_dig;

    logic              w_accept;
    logic              w_overRange;
    logic              w_start;
    logic              w_finish;
    logic [BIN_W-1:0]  w_capVal;
    logic [BCD_W-1:0]  w_bcd;
    logic [BCD_W-1:0]  w_errPat;
    logic [BCD_W-1:0]  w_commitVal;
    logic [3:0]        w_curNibble;

    assign w_accept    = (r_state == IDLE) && (load || r_pendValid);
    assign w_capVal    = r_pendValid ? r_pendVal : value;
    assign w_overRange = ({32'd0, w_capVal} > {{BIN_W{1'b0}}, MAX_VALUE});
    assign w_start     = w_accept && !w_overRange;

    bcd_double_dabble #(
        .BIN_W (BIN_W),
        .BCD_W (BCD_W)
    ) u_dabble (
        .clock  (clock),
        .reset  (reset),
        .start  (w_start),
        .bin    (w_capVal),
        .bcd    (w_bcd),
        .finish (w_finish)
    );

    always_comb begin
        w_errPat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_errPat[i*4 +: 4] = (i == 0) ? ERR_CODE : BLANK_CODE;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_seen;

    // Position 0 is never blanked so that a zero result still shows a single 0.
    always_comb begin
        w_commitVal = w_bcd;
        w_seen      = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (!w_seen && (w_bcd[i*4 +: 4] == 4'd0)) begin
                w_commitVal[i*4 +: 4] = BLANK_CODE;
            end else begin
                w_seen = 1'b1;
            end
        end
        if (r_err) begin
            w_commitVal = w_errPat;
        end
    end
`else
    always_comb begin
        w_commitVal = r_err ? w_errPat : w_bcd;
    end
`endif

    // A load that cannot start right away lands in the one-deep pending slot; newest wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendVal   <= '0;
            r_disp      <= '0;
        end else begin
            r_done <= 1'b0;

            if (load && ((r_state != IDLE) || r_pendValid)) begin
                r_pendVal   <= value;
                r_pendValid <= 1'b1;
            end else if (w_accept) begin
                r_pendValid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_busy  <= 1'b1;
                        r_err   <= w_overRange;
                        r_state <= w_overRange ? COMMIT : CONV;
                    end
                end
                CONV: begin
                    if (w_finish) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_disp  <= w_commitVal;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_curNibble = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_pos == 4'(i)) begin
                w_curNibble = r_disp[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_scanCnt <= '0;
            r_pos     <= '0;
            r_dig     <= '0;
        end else begin
            r_dig <= w_curNibble;
            if (r_scanCnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scanCnt <= '0;
                r_pos     <= (r_pos == 4'(DIGITS - 1)) ? 4'd0 : r_pos + 4'd1;
            end else begin
                r_scanCnt <= r_scanCnt + 1'b1;
            end
        end
    end

    // The error override sits after the register so the stored digits survive an ERRO spell.
    assign dig  = (status == ERRO) ? ((r_pos == 4'd0) ? ERR_CODE : BLANK_CODE) : r_dig;
    assign busy = r_busy;
    assign done = r_done;
    assign pos  = r_pos;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Scoreboard bench for calc_display_ctrl: stimulus queues expected commits, a monitor checks them.
module tb_calc_display_ctrl;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;
    localparam int BIN_W    = 32;

    typedef struct packed {
        logic [31:0] digs;
        logic [31:0] cyc;
        logic        scan;
    } expEntry_t;

    logic             clock;
    logic             reset;
    logic [BIN_W-1:0] value;
    logic             load;
    logic [1:0]       status;
    logic             busy;
    logic             done;
    logic [3:0]       pos;
    logic [3:0]       dig;

    int        nChecks;
    int        nFail;
    int        cyc;
    bit        monBusy;
    expEntry_t expQ[$];
    expEntry_t monEntry;

    calc_display_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BIN_W    (BIN_W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .value  (value),
        .load   (load),
        .status (status),
        .busy   (busy),
        .done   (done),
        .pos    (pos),
        .dig    (dig)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent decimal model of what the eight scanned positions should show.
    function automatic logic [31:0] expDigits(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = v;
        if (v > 32'd99999999) return 32'hFFFF_FFFE;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 7; i >= 1; i--) begin
            if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
            else break;
        end
`endif
        return r;
    endfunction

    task automatic waitCyc(input int t);
        do @(negedge clock); while (cyc < t);
    endtask

    task automatic applyStimulus(input logic [31:0] v, output int n);
        @(negedge clock);
        value = v;
        load  = 1'b1;
        n     = cyc;
        @(negedge clock);
        load  = 1'b0;
    endtask

    task automatic pushExp(input logic [31:0] digs, input int doneCyc, input logic scan);
        expEntry_t e;
        e.digs = digs;
        e.cyc  = 32'(doneCyc);
        e.scan = scan;
        expQ.push_back(e);
    endtask

    // Walks one full scan, checking each digit once its position has been stable for a cycle.
    task automatic scanCheck(input logic [31:0] exp);
        bit [7:0]   seen;
        int         budget;
        int         lastChange;
        logic [3:0] prevPos;
        seen       = '0;
        budget     = 0;
        lastChange = -1;
        prevPos    = pos;
        while (seen != 8'hFF && budget < 100) begin
            @(negedge clock);
            budget++;
            if (pos == prevPos) begin
                if (pos < 4'd8 && !seen[pos[2:0]]) begin
                    checkOutput("scanDig", {28'd0, dig}, {28'd0, exp[pos*4 +: 4]});
                    seen[pos[2:0]] = 1'b1;
                end
            end else begin
                checkOutput("scanStep", {28'd0, pos}, {28'd0, 4'((prevPos + 4'd1) % 4'd8)});
                if (lastChange >= 0) checkOutput("scanPeriod", 32'(budget - lastChange), 32'(SCAN_DIV));
                lastChange = budget;
            end
            prevPos = pos;
        end
        checkOutput("scanComplete", {24'd0, seen}, 32'h0000_00FF);
    endtask

    task automatic waitDrain();
        int k;
        k = 0;
        while ((expQ.size() != 0 || monBusy) && k < 400) begin
            @(negedge clock);
            k++;
        end
        checkOutput("drainTimeout", 32'(k < 400), 32'd1);
    endtask

    initial begin
        monBusy = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    monEntry = expQ.pop_front();
                    monBusy  = 1'b1;
                    checkOutput("doneCycle", 32'(cyc), monEntry.cyc);
                    checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
                    if (monEntry.scan) begin
                        @(negedge clock);
                        scanCheck(monEntry.digs);
                    end
                    monBusy = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int n2;
        nChecks = 0;
        nFail   = 0;
        reset   = 1'b0;
        value   = '0;
        load    = 1'b0;
        status  = 2'd1;

        repeat (3) @(negedge clock);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetPos", {28'd0, pos}, 32'd0);
        checkOutput("resetDig", {28'd0, dig}, 32'd0);
        reset = 1'b1;

        $display("[TB] reset in the middle of a conversion");
        applyStimulus(32'd12345, n);
        waitCyc(n + 10);
        checkOutput("midConvBusy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midResetPos", {28'd0, pos}, 32'd0);
        checkOutput("midResetDig", {28'd0, dig}, 32'd0);
        checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("midResetDone", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (50) @(negedge clock);
        checkOutput("postResetIdle", {31'd0, busy}, 32'd0);

        $display("[TB] load 12345 and scan");
        applyStimulus(32'd12345, n);
        pushExp(expDigits(32'd12345), n + 34, 1'b1);
        checkOutput("busyFirst", {31'd0, busy}, 32'd1);
        waitCyc(n + 33);
        checkOutput("busyLast", {31'd0, busy}, 32'd1);
        waitDrain();

        $display("[TB] status ERRO overrides then releases");
        @(negedge clock);
        status = 2'd0;
        scanCheck(32'hFFFF_FFFE);
        status = 2'd1;
        @(negedge clock);
        scanCheck(expDigits(32'd12345));

        $display("[TB] out-of-range value");
        applyStimulus(32'd100000000, n);
        pushExp(32'hFFFF_FFFE, n + 2, 1'b1);
        waitDrain();

        $display("[TB] loads while busy, last wins");
        applyStimulus(32'd7, n);
        pushExp(expDigits(32'd7), n + 34, 1'b0);
        applyStimulus(32'd42, n2);
        applyStimulus(32'd99, n2);
        pushExp(expDigits(32'd99), n + 68, 1'b1);
        waitDrain();

        $display("[TB] load coinciding with COMMIT");
        applyStimulus(32'd1, n);
        pushExp(expDigits(32'd1), n + 34, 1'b0);
        waitCyc(n + 32);
        applyStimulus(32'd87654321, n2);
        checkOutput("loadAtCommitCyc", 32'(n2), 32'(n + 33));
        pushExp(expDigits(32'd87654321), n + 68, 1'b1);
        waitDrain();

        $display("[TB] OCUPADA and status 3 keep showing digits");
        status = 2'd2;
        applyStimulus(32'd305, n);
        pushExp(expDigits(32'd305), n + 34, 1'b1);
        waitDrain();
        status = 2'd3;
        @(negedge clock);
        scanCheck(expDigits(32'd305));
        status = 2'd1;

        $display("[TB] zero and maximum values");
        applyStimulus(32'd0, n);
        pushExp(expDigits(32'd0), n + 34, 1'b1);
        waitDrain();
        applyStimulus(32'd99999999, n);
        pushExp(expDigits(32'd99999999), n + 34, 1'b1);
        waitDrain();

        repeat (40) @(negedge clock);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/calc_display_ctrl.md
Name: calc_display_ctrl

Overview:
- Display controller for the calculator datapath.
- Takes the calculator's binary result and its 2-bit status, converts the result to BCD with a sequential double-dabble, and time-multiplexes the digits onto a shared pos/dig display bus.
- Sits between the calculator core and the multiplexed 7-segment driver.
- Replaces the core's single-digit dig/pos drive with a full scan.

Parameters:
- DIGITS, 8: number of display positions scanned (1..8).
- SCAN_DIV, 1000: clock cycles each position is held before advancing (>=2).
- BIN_W, 32: width of the binary value input.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- value  in  BIN_W  binary result from calculator core.
- load  in  1  single-cycle request to display value.
- status  in  2  calculator state: 0=ERRO, 1=PRONTA, 2=OCUPADA.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- pos  out  4  current display position, 0 = least significant.
- dig  out  4  code for pos: 0-9 digit, 4'hE error glyph, 4'hF blank.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE.
  - busy=0, done=0, pos=0, dig=0.
  - Display register all zeros; pending flag cleared; scan counter 0.
- FSM states IDLE, CONV, COMMIT.
  - IDLE: if load=1 or pending=1, capture value into the shift register (or the pending copy if one is waiting), clear pending, busy=1, go to CONV.
  - CONV: exactly BIN_W shift cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left one bit, MSB of the binary in. Then go to COMMIT.
  - COMMIT: write all DIGITS nibbles to the display register in one cycle (no torn display). done=1 for this cycle only, busy=0, return to IDLE.
- Latency: load accepted in cycle N gives done in cycle N+BIN_W+2; dig reflects the new value from cycle N+BIN_W+3.
- Out-of-range input: a captured value > 99999999 skips CONV. COMMIT loads the error pattern: 4'hE at pos 0, 4'hF elsewhere.
- Load while busy: value latched into a one-deep pending slot; a later load overwrites it (last wins). The slot is consumed on the IDLE cycle after COMMIT.
- Simultaneous load and COMMIT: the load goes to pending, not lost.
- Status gating:
  - status=ERRO forces dig to the error pattern, combinationally over the display register. The display register is not modified.
  - status=OCUPADA: loads are still accepted; the display keeps the last committed digits.
  - Status 3 is treated as PRONTA.
- Scan:
  - A free-running divider counts 0..SCAN_DIV-1. On wrap, pos increments and wraps from DIGITS-1 to 0.
  - dig = display nibble[pos], registered (one cycle behind pos change).
  - Scan runs regardless of FSM state.
- Arithmetic:
  - BCD register 4*DIGITS bits.
  - Range check against 99999999 is done on the full BIN_W value before truncation.

Optional Feature:
- LEADING_ZERO_BLANK_EN
  - Defined: at COMMIT, nibbles above the most significant non-zero digit are replaced by 4'hF. Value 0 shows 0 at pos 0 and blanks elsewhere.
  - Undefined: all DIGITS positions show numeric digits, including leading zeros.

Decomposition:
- Package calc_pkg:
  - statetype enum {ERRO, PRONTA, OCUPADA}, 2-bit, shared with the core.
  - Constants BLANK_CODE=4'hF, ERR_CODE=4'hE, MAX_VALUE=32'd99999999.
- Sub-module bcd_double_dabble (the shift/add-3 engine).
  - Ports: start, bin in, bcd out, finish pulse.
  - The FSM, pending slot and scan logic stay in calc_display_ctrl.

Test Plan (DIGITS=8, SCAN_DIV=4, BIN_W=32):
- Reset mid-conversion: load 12345, drop reset at cycle 10 → pos=0, dig=0, busy=0 immediately. No done pulse afterwards.
- Load 12345 at cycle 0 → busy 1..33, done=1 at cycle 34. Scanning pos 0..7 gives dig 5,4,3,2,1,0,0,0; pos advances every 4 cycles and wraps 7→0.
- Load 100000000 → done after 2 cycles, no CONV. Scan shows E at pos 0, F at pos 1..7.
- Load 7 then load 42 then load 99 while busy → done for 7, then one more conversion showing 99. 42 is never displayed.
- Display 12345, then drive status=ERRO → E/F pattern. Return status=PRONTA → 12345 reappears without a new load.
- LEADING_ZERO_BLANK_EN defined: load 305 → dig 5,0,3,F,F,F,F,F. Load 0 → 0,F,F,F,F,F,F,F.
